instruction_dispatcher: RTL and testbench

- Front-end control stage of the mini serial processor, directly upstream of the ALU.
- Fetches 16-bit instruction words from memory, decodes them into the package Instruction fields and reads operands from an internal 16x32 register bank.
- ADD/AND/OR/MUL/SHL/SHR: builds an AluPacket, hands it to the ALU over valid/ready, then writes the returned result back to rd.
- LW/SW: executed locally against the shared memory port.

---
 rtl/instruction_dispatcher_pkg.sv | 47 ++++
 rtl/instruction_dispatcher_if.sv | 26 ++
 rtl/instruction_dispatcher_register_bank.sv | 28 ++
 rtl/instruction_dispatcher.sv | 133 +++++++++++++
 tb/tb_instruction_dispatcher.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/instruction_dispatcher_pkg.sv
// ISA types shared by the dispatcher, its register bank and the ALU.
// Dispatcher-specific additions: FSM state enum, HALT bit position, decode helper.
package instruction_dispatcher_pkg;

    localparam int MEMORY_ADDRESS_WIDTH = 8;
    localparam int MEMORY_DATA_WIDTH    = 16;
    localparam int REGISTER_SIZE        = 32;
    localparam int REGISTER_BANK_SIZE   = 16;
    localparam int REG_ADDR_WIDTH       = $clog2(REGISTER_BANK_SIZE);

    typedef enum logic [2:0] {
        ADD = 3'd0,
        AND = 3'd1,
        OR  = 3'd2,
        MUL = 3'd3,
        SHL = 3'd4,
        SHR = 3'd5,
        LW  = 3'd6,
        SW  = 3'd7
    } Operation;

    typedef struct packed {
        Operation                  op_code;
        logic [REG_ADDR_WIDTH-1:0] rs_1;
        logic [REG_ADDR_WIDTH-1:0] rs_2;
        logic [REG_ADDR_WIDTH-1:0] rd;
    } Instruction;

    typedef struct packed {
        logic [REGISTER_SIZE-1:0] op_2;
        logic [REGISTER_SIZE-1:0] op_1;
        Operation                 op_code;
    } AluPacket;

    typedef enum logic [3:0] {
        IDLE, FETCH, DECODE, ISSUE, WAIT_RESULT,
        MEM_ACCESS, MEM_WAIT, WRITEBACK, HALTED
    } DispatcherState;

    localparam int HALT_BIT          = 15;
    localparam int INSTRUCTION_WIDTH = $bits(Instruction);

    function automatic logic is_alu_op(Operation op);
        return !(op == LW || op == SW);
    endfunction

endpackage

// File: rtl/instruction_dispatcher_if.sv
// Shared memory port plus ALU valid/ready channel seen by the dispatcher.
interface instruction_dispatcher_if;
    import instruction_dispatcher_pkg::*;

    logic [MEMORY_ADDRESS_WIDTH-1:0] mem_addr;
    logic                            mem_read;
    logic                            mem_write;
    logic [MEMORY_DATA_WIDTH-1:0]    mem_wr_data;
    logic [MEMORY_DATA_WIDTH-1:0]    mem_rd_data;
    AluPacket                        alu_packet;
    logic                            alu_valid;
    logic                            alu_ready;
    logic [REGISTER_SIZE-1:0]        alu_result;
    logic                            alu_result_valid;

    modport master (
        output mem_addr, mem_read, mem_write, mem_wr_data, alu_packet, alu_valid,
        input  mem_rd_data, alu_ready, alu_result, alu_result_valid
    );

    modport slave (
        input  mem_addr, mem_read, mem_write, mem_wr_data, alu_packet, alu_valid,
        output mem_rd_data, alu_ready, alu_result, alu_result_valid
    );

endinterface

// File: rtl/instruction_dispatcher_register_bank.sv
// 16x32 register file: two asynchronous read ports, one synchronous write port.
module register_bank
    import instruction_dispatcher_pkg::*;
(
    input  logic                      clock,
    input  logic                      reset,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_a,
    input  logic [REG_ADDR_WIDTH-1:0] rd_addr_b,
    output logic [REGISTER_SIZE-1:0]  rd_data_a,
    output logic [REGISTER_SIZE-1:0]  rd_data_b,
    input  logic                      wr_en,
    input  logic [REG_ADDR_WIDTH-1:0] wr_addr,
    input  logic [REGISTER_SIZE-1:0]  wr_data
);

    logic [REGISTER_BANK_SIZE-1:0][REGISTER_SIZE-1:0] regs;

    always_ff @(posedge clock or posedge reset) begin
        if (reset)
            regs <= '0;
        else if (wr_en)
            regs[wr_addr] <= wr_data;
    end

    assign rd_data_a = regs[rd_addr_a];
    assign rd_data_b = regs[rd_addr_b];

endmodule

// File: rtl/instruction_dispatcher.sv
// Fetch/decode/issue front end: runs ALU ops through the external ALU,
// executes LW/SW locally on the shared memory port.
module instruction_dispatcher
    import instruction_dispatcher_pkg::*;
#(
    parameter logic [MEMORY_ADDRESS_WIDTH-1:0] RESET_PC = 8'h00
) (
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            start,
    instruction_dispatcher_if.master        bus,
    output logic [MEMORY_ADDRESS_WIDTH-1:0] pc,
    output logic                            busy,
    output logic                            halted
);

    DispatcherState                  state;
    Instruction                      ir;
    Instruction                      fetched;
    logic [REGISTER_SIZE-1:0]        result_q;
    logic [REG_ADDR_WIDTH-1:0]       rd_addr_a, rd_addr_b;
    logic [REGISTER_SIZE-1:0]        rd_data_a, rd_data_b;
    logic [MEMORY_ADDRESS_WIDTH-1:0] next_pc;

    assign fetched = Instruction'(bus.mem_rd_data[INSTRUCTION_WIDTH-1:0]);
    assign next_pc = pc + 8'd1;

    // Operands come straight off the memory bus in DECODE so the packet can
    // be registered on the DECODE edge; later states read through ir.
    always_comb begin
        rd_addr_a = ir.rs_1;
        rd_addr_b = ir.rs_2;
        if (state == DECODE) begin
            rd_addr_a = fetched.rs_1;
            rd_addr_b = fetched.rs_2;
        end
    end

    register_bank u_bank (
        .clock     (clock),
        .reset     (reset),
        .rd_addr_a (rd_addr_a),
        .rd_addr_b (rd_addr_b),
        .rd_data_a (rd_data_a),
        .rd_data_b (rd_data_b),
        .wr_en     (state == WRITEBACK),
        .wr_addr   (ir.rd),
        .wr_data   (result_q)
    );

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state           <= IDLE;
            pc              <= RESET_PC;
            ir              <= '0;
            result_q        <= '0;
            busy            <= 1'b0;
            halted          <= 1'b0;
            bus.mem_addr    <= '0;
            bus.mem_read    <= 1'b0;
            bus.mem_write   <= 1'b0;
            bus.mem_wr_data <= '0;
            bus.alu_packet  <= '0;
            bus.alu_valid   <= 1'b0;
        end else begin
            bus.mem_read  <= 1'b0;
            bus.mem_write <= 1'b0;
            case (state)
                IDLE, HALTED: if (start) begin
                    state        <= FETCH;
                    pc           <= RESET_PC;
                    bus.mem_addr <= RESET_PC;
                    bus.mem_read <= 1'b1;
                    busy         <= 1'b1;
                    halted       <= 1'b0;
                end
                FETCH: state <= DECODE;
                DECODE: begin
                    ir <= fetched;
                    if (bus.mem_rd_data[HALT_BIT]) begin
                        state  <= HALTED;
                        busy   <= 1'b0;
                        halted <= 1'b1;
                    end else if (is_alu_op(fetched.op_code)) begin
                        state          <= ISSUE;
                        bus.alu_valid  <= 1'b1;
                        bus.alu_packet <= '{op_2: rd_data_b, op_1: rd_data_a,
                                            op_code: fetched.op_code};
                    end else begin
                        state        <= MEM_ACCESS;
                        bus.mem_addr <= rd_data_a[MEMORY_ADDRESS_WIDTH-1:0];
                        if (fetched.op_code == SW) begin
                            bus.mem_write   <= 1'b1;
                            bus.mem_wr_data <= rd_data_b[MEMORY_DATA_WIDTH-1:0];
                        end else begin
                            bus.mem_read <= 1'b1;
                        end
                    end
                end
                ISSUE: if (bus.alu_ready) begin
                    bus.alu_valid <= 1'b0;
                    state         <= WAIT_RESULT;
                end
                WAIT_RESULT: if (bus.alu_result_valid) begin
                    result_q <= bus.alu_result;
                    state    <= WRITEBACK;
                end
                MEM_ACCESS: begin
                    if (ir.op_code == SW) begin
                        pc           <= next_pc;
                        bus.mem_addr <= next_pc;
                        bus.mem_read <= 1'b1;
                        state        <= FETCH;
                    end else begin
                        state <= MEM_WAIT;
                    end
                end
                MEM_WAIT: begin
                    result_q <= {{(REGISTER_SIZE-MEMORY_DATA_WIDTH){1'b0}}, bus.mem_rd_data};
                    state    <= WRITEBACK;
                end
                WRITEBACK: begin
                    pc           <= next_pc;
                    bus.mem_addr <= next_pc;
                    bus.mem_read <= 1'b1;
                    state        <= FETCH;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_instruction_dispatcher.sv
// Drives the dispatcher as memory + ALU and checks every bus event against an
// instruction-level model of the ISA (program counter, registers, memory).
module tb_instruction_dispatcher;
    import instruction_dispatcher_pkg::*;

    localparam logic [7:0] RPC = 8'hFF;

    logic       clock = 1'b0;
    logic       reset;
    logic       start;
    logic [7:0] pc;
    logic       busy, halted;

    instruction_dispatcher_if bus ();

    instruction_dispatcher #(.RESET_PC(RPC)) dut (
        .clock  (clock),
        .reset  (reset),
        .start  (start),
        .bus    (bus),
        .pc     (pc),
        .busy   (busy),
        .halted (halted)
    );

    always #5 clock = ~clock;

    logic [15:0] mem   [256];
    logic [15:0] m_mem [256];
    logic [31:0] m_regs[16];
    logic [7:0]  m_pc;
    logic [66:0] last_pkt;
    int          ntests = 0;
    int          nfail  = 0;

    always @(posedge clock)
        if (bus.mem_read) bus.mem_rd_data <= mem[bus.mem_addr];

    task automatic check(input string tag, input logic [66:0] obs, input logic [66:0] exp);
        ntests++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        @(negedge clock);
    endtask

    // Inputs that the DUT must ignore in the current cycle get random values.
    task automatic noise();
        start                = 1'($urandom_range(0, 1));
        bus.alu_ready        = 1'($urandom_range(0, 1));
        bus.alu_result_valid = 1'b0;
        bus.alu_result       = $urandom;
    endtask

    task automatic set_mem(input logic [7:0] a, input logic [15:0] d);
        mem[a]   = d;
        m_mem[a] = d;
    endtask

    function automatic logic [31:0] alu_fn(input Operation op, input logic [31:0] a, input logic [31:0] b);
        case (op)
            ADD:     return a + b;
            AND:     return a & b;
            OR:      return a | b;
            MUL:     return a * b;
            SHL:     return a << b[4:0];
            default: return a >> b[4:0];
        endcase
    endfunction

    task automatic run_program(input int smin, input int smax, input int lmax);
        logic [15:0] word;
        Instruction  ins;
        logic [7:0]  a;
        logic [66:0] exp;
        logic [31:0] res;
        int          s, lat;
        bit          done;
        start = 1'b1; bus.alu_ready = 1'b0; bus.alu_result_valid = 1'b0;
        step();
        m_pc = RPC;
        done = 1'b0;
        for (int n = 0; n < 64 && !done; n++) begin
            word = m_mem[m_pc];
            ins  = Instruction'(word[14:0]);
            check("fetch", 67'({bus.mem_read, bus.mem_write, bus.mem_addr, pc, busy}),
                  67'({1'b1, 1'b0, m_pc, m_pc, 1'b1}));
            noise(); step();
            check("decode_quiet", 67'({bus.mem_read, bus.mem_write, bus.alu_valid}), 67'(0));
            noise(); step();
            if (word[15]) begin
                check("halt", 67'({halted, busy, pc, bus.mem_read, bus.mem_write}),
                      67'({1'b1, 1'b0, m_pc, 1'b0, 1'b0}));
                start = 1'b0;
                done  = 1'b1;
            end else if (ins.op_code == SW) begin
                a = m_regs[ins.rs_1][7:0];
                check("sw", 67'({bus.mem_read, bus.mem_write, bus.mem_addr, bus.mem_wr_data}),
                      67'({1'b0, 1'b1, a, m_regs[ins.rs_2][15:0]}));
                mem[bus.mem_addr] = bus.mem_wr_data;
                m_mem[a]          = m_regs[ins.rs_2][15:0];
                m_pc++;
                noise(); step();
            end else if (ins.op_code == LW) begin
                a = m_regs[ins.rs_1][7:0];
                check("lw", 67'({bus.mem_read, bus.mem_write, bus.mem_addr}), 67'({1'b1, 1'b0, a}));
                m_regs[ins.rd] = {16'h0, m_mem[a]};
                m_pc++;
                noise(); step();
                noise(); step();
                noise(); step();
            end else begin
                exp = {m_regs[ins.rs_2], m_regs[ins.rs_1], ins.op_code};
                s   = $urandom_range(smin, smax);
                for (int k = 0; k <= s; k++) begin
                    check("issue", {bus.alu_valid, bus.mem_read, bus.mem_write} == 3'b100 ? bus.alu_packet : 67'h0, exp);
                    start                = 1'($urandom_range(0, 1));
                    bus.alu_ready        = (k == s);
                    bus.alu_result_valid = (k == s) && ($urandom_range(0, 1) == 1);
                    bus.alu_result       = $urandom;
                    if (k == s) last_pkt = bus.alu_packet;
                    step();
                end
                res = alu_fn(ins.op_code, m_regs[ins.rs_1], m_regs[ins.rs_2]);
                lat = $urandom_range(1, lmax);
                for (int k = 1; k <= lat; k++) begin
                    check("valid_drop", 67'(bus.alu_valid), 67'(0));
                    start                = 1'($urandom_range(0, 1));
                    bus.alu_ready        = 1'($urandom_range(0, 1));
                    bus.alu_result_valid = (k == lat);
                    bus.alu_result       = (k == lat) ? res : $urandom;
                    step();
                end
                noise(); step();
                m_regs[ins.rd] = res;
                m_pc++;
            end
        end
        check("terminated", 67'(done), 67'(1));
    endtask

    // R14 = mem[0] = 16'h6E8k, whose low byte points the second LW at mem[0x8k].
    task automatic load_reg(input logic [3:0] k, input logic [15:0] v);
        set_mem(8'hFF, 16'h600E);
        set_mem(8'h00, {12'h6E8, k});
        set_mem(8'h01, 16'h8000);
        set_mem({4'h8, k}, v);
        run_program(0, 2, 3);
    endtask

    task automatic mid_reset(input bit in_wait);
        set_mem(8'hFF, 16'h012B);
        set_mem(8'h00, 16'h8000);
        start = 1'b1; bus.alu_ready = 1'b0; bus.alu_result_valid = 1'b0;
        step(); start = 1'b0;
        step();
        step();
        check("pre_reset_valid", 67'({bus.alu_valid, busy}), 67'(2'b11));
        if (in_wait) begin
            bus.alu_ready = 1'b1;
            step();
            bus.alu_ready = 1'b0;
            check("in_wait", 67'({bus.alu_valid, busy}), 67'(2'b01));
        end
        #1 reset = 1'b1;
        #1;
        check("async_reset", 67'({bus.alu_valid, busy, halted, bus.mem_read, bus.mem_write,
                                  pc, bus.mem_addr, bus.mem_wr_data}),
              67'({5'b0, RPC, 8'h00, 16'h0}));
        check("async_reset_pkt", bus.alu_packet, 67'h0);
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        bus.alu_result_valid = 1'b1;
        bus.alu_result       = 32'h1234_5678;
        step();
        bus.alu_result_valid = 1'b0;
        step();
        check("idle_after_reset", 67'({busy, halted, pc}), 67'({1'b0, 1'b0, RPC}));
    endtask

    initial begin
        reset = 1'b1; start = 1'b0;
        bus.alu_ready = 1'b0; bus.alu_result_valid = 1'b0; bus.alu_result = '0;
        for (int i = 0; i < 256; i++) set_mem(8'(i), 16'h8000);
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        @(negedge clock); @(negedge clock);
        check("reset_outputs", 67'({bus.alu_valid, busy, halted, bus.mem_read, bus.mem_write,
                                    pc, bus.mem_addr, bus.mem_wr_data}),
              67'({5'b0, RPC, 8'h00, 16'h0}));
        check("reset_pkt", bus.alu_packet, 67'h0);
        reset = 1'b0;
        step();

        load_reg(4'd1, 16'd5);
        load_reg(4'd2, 16'd7);
        set_mem(8'hFF, 16'h0123);
        set_mem(8'h00, 16'h8000);
        run_program(0, 0, 1);
        check("add_pkt", last_pkt, {32'd7, 32'd5, ADD});
        check("add_halt_pc", 67'({halted, pc}), 67'({1'b1, 8'h00}));
        run_program(4, 4, 3);
        check("stall_pkt", last_pkt, {32'd7, 32'd5, ADD});
        set_mem(8'hFF, 16'h030A);
        run_program(0, 1, 2);
        check("r3_retained", last_pkt, {32'd0, 32'd12, ADD});

        load_reg(4'd4, 16'h0020);
        load_reg(4'd5, 16'hDEAD);
        load_reg(4'd8, 16'd16);
        load_reg(4'd9, 16'hBEEF);
        set_mem(8'hFF, 16'h4585);
        set_mem(8'h00, 16'h2595);
        set_mem(8'h01, 16'h7450);
        set_mem(8'h02, 16'h6406);
        set_mem(8'h03, 16'h0607);
        set_mem(8'h04, 16'h8000);
        run_program(0, 2, 3);
        check("sw_mem", 67'(mem[8'h20]), 67'(16'hBEEF));
        check("lw_r6", last_pkt, {32'd0, 32'h0000_BEEF, ADD});

        for (int i = 0; i < 4; i++) load_reg(4'($urandom_range(1, 13)), 16'($urandom));
        for (int r = 0; r < 6; r++) begin
            for (int i = 0; i < 256; i++) set_mem(8'(i), 16'h8000);
            for (int i = 0; i < 7; i++) set_mem(8'(8'hFF + i), {1'b0, 15'($urandom)});
            run_program(0, 3, 4);
        end

        mid_reset(1'b0);
        mid_reset(1'b1);
        for (int i = 0; i < 256; i++) set_mem(8'(i), 16'h8000);
        set_mem(8'hFF, 16'h0B0C);
        run_program(0, 1, 2);
        check("no_late_write", last_pkt, {32'd0, 32'd0, ADD});

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

endmodule
